// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle RV32I issue controller for a registered ALU
// Optional branch decode and out_taken port: `define ALU_ISSUE_BRANCH_EN
module alu_issue_ctrl #(
  parameter logic [3:0] IDLE_CTR = 4'b0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic [3:0]  ALU_ctr,
  output logic [31:0] ALU_srcA,
  output logic [31:0] ALU_srcB,
  input  logic [31:0] ALU_resp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_illegal
`ifdef ALU_ISSUE_BRANCH_EN
  ,
  output logic        out_taken
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd14;
  localparam logic [3:0] OP_SLTU = 4'd15;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  logic [1:0]  r_state;
  logic [3:0]  r_ctr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_we;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_rd;
  logic        r_out_we;
  logic        r_out_illegal;

  logic        w_legal;
  logic        w_is_br;
  logic [3:0]  w_ctr;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_we;

  wire [6:0] w_opc   = in_instr[6:0];
  wire [2:0] w_f3    = in_instr[14:12];
  wire [6:0] w_f7    = in_instr[31:25];
  wire [4:0] w_rd    = in_instr[11:7];
  wire [31:0] w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  wire [31:0] w_imm_u = {in_instr[31:12], 12'b0};
  wire [31:0] w_shamt = {27'b0, in_instr[24:20]};
  wire        w_unused_rs1_field = ^in_instr[19:15];

  function automatic logic [3:0] f_base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f_base_op = OP_ADD;
      3'b001:  f_base_op = OP_SLL;
      3'b010:  f_base_op = OP_SLT;
      3'b011:  f_base_op = OP_SLTU;
      3'b100:  f_base_op = OP_XOR;
      3'b101:  f_base_op = OP_SRL;
      3'b110:  f_base_op = OP_OR;
      default: f_base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    w_legal = 1'b0;
    w_is_br = 1'b0;
    w_ctr   = OP_ADD;
    w_a     = in_rs1_val;
    w_b     = in_rs2_val;
    case (w_opc)
      OPC_R: begin
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          w_ctr   = f_base_op(w_f3);
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_legal = 1'b1;
          w_ctr   = OP_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_legal = 1'b1;
          w_ctr   = OP_SRA;
        end
      end
      OPC_I: begin
        w_b = w_imm_i;
        // Shift-immediates hand the ALU just the 5-bit shamt, not the funct7 bits.
        if (w_f3 == 3'b001) begin
          w_b     = w_shamt;
          w_ctr   = OP_SLL;
          w_legal = (w_f7 == 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_b     = w_shamt;
          w_ctr   = (w_f7 == 7'b0100000) ? OP_SRA : OP_SRL;
          w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        end else begin
          w_ctr   = f_base_op(w_f3);
          w_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_a     = 32'b0;
        w_b     = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_a     = in_pc;
        w_b     = w_imm_u;
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BR: begin
        w_is_br = 1'b1;
        case (w_f3)
          3'b000, 3'b001: begin w_legal = 1'b1; w_ctr = OP_SUB;  end
          3'b100, 3'b101: begin w_legal = 1'b1; w_ctr = OP_SLT;  end
          3'b110, 3'b111: begin w_legal = 1'b1; w_ctr = OP_SLTU; end
          default:        w_legal = 1'b0;
        endcase
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign w_we = (w_rd != 5'd0) && !w_is_br;

`ifdef ALU_ISSUE_BRANCH_EN
  logic       r_is_br;
  logic [2:0] r_f3;
  logic       r_out_taken;
  logic       w_taken;

  always_comb begin
    w_taken = 1'b0;
    case (r_f3)
      3'b000:         w_taken = (ALU_resp == 32'd0);
      3'b001:         w_taken = (ALU_resp != 32'd0);
      3'b100, 3'b110: w_taken = ALU_resp[0];
      3'b101, 3'b111: w_taken = !ALU_resp[0];
      default:        w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_br     <= 1'b0;
      r_f3        <= 3'b0;
      r_out_taken <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_is_br     <= w_is_br && w_legal;
      r_f3        <= w_f3;
      r_out_taken <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_out_taken <= r_is_br && w_taken;
    end
  end

  assign out_taken = r_out_taken;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_ctr         <= OP_ADD;
      r_a           <= 32'b0;
      r_b           <= 32'b0;
      r_rd          <= 5'b0;
      r_we          <= 1'b0;
      r_out_result  <= 32'b0;
      r_out_rd      <= 5'b0;
      r_out_we      <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ctr <= w_ctr;
            r_a   <= w_a;
            r_b   <= w_b;
            r_rd  <= w_rd;
            r_we  <= w_we;
            if (w_legal) begin
              r_state <= S_ISSUE;
            end else begin
              r_state       <= S_DONE;
              r_out_result  <= 32'b0;
              r_out_rd      <= w_rd;
              r_out_we      <= 1'b0;
              r_out_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_state       <= S_DONE;
          r_out_result  <= ALU_resp;
          r_out_rd      <= r_rd;
          r_out_we      <= r_we;
          r_out_illegal <= 1'b0;
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Operands are only presented during ISSUE so the ALU never sees stale data.
  assign ALU_ctr     = (r_state == S_ISSUE) ? r_ctr : IDLE_CTR;
  assign ALU_srcA    = (r_state == S_ISSUE) ? r_a : 32'b0;
  assign ALU_srcB    = (r_state == S_ISSUE) ? r_b : 32'b0;
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_out_result;
  assign out_rd      = r_out_rd;
  assign out_we      = r_out_we;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - vector table, random reference-model and corner-sequence bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_val = '0, in_rs2_val = '0;
  logic [3:0]  ALU_ctr;
  logic [31:0] ALU_srcA, ALU_srcB;
  logic [31:0] ALU_resp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
  logic        out_taken;
`endif

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.IDLE_CTR(4'b0000)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .ALU_ctr(ALU_ctr), .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .ALU_resp(ALU_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_BRANCH_EN
    , .out_taken(out_taken)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return {31'b0, $signed(a) < $signed(b)};
      4'd14: return 32'($signed(a) >>> b[4:0]);
      4'd15: return {31'b0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Registered ALU: one-cycle latency from operands to ALU_resp.
  always @(posedge clk) ALU_resp <= alu_fn(ALU_ctr, ALU_srcA, ALU_srcB);

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        legal, chk_issue;
    logic [3:0]  ctr;
    logic [31:0] a, b, result;
    logic        we;
    logic [4:0]  rd;
    logic        chk_rd, taken;
  } vec_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] u, input logic [4:0] rd, input logic [6:0] op);
    return {u, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2, input logic legal, input logic [3:0] ctr,
                              input logic [31:0] a, b, result, input logic we, input logic [4:0] rd,
                              input logic chk_rd, input logic taken);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.legal = legal; v.chk_issue = legal;
    v.ctr = ctr; v.a = a; v.b = b; v.result = result; v.we = we; v.rd = rd; v.chk_rd = chk_rd; v.taken = taken;
    return v;
  endfunction

  // Instruction-level semantics: what RV32I says the instruction computes.
  function automatic vec_t ref_model(input logic [31:0] instr, pc, a, b);
    vec_t v;
    logic [6:0] f7 = instr[31:25];
    logic [2:0] f3 = instr[14:12];
    logic [31:0] imm = {{20{instr[31]}}, instr[31:20]};
    logic [4:0] sh = instr[24:20];
    logic br = 1'b0;
    v = mk(instr, pc, a, b, 1'b1, 4'd0, 0, 0, 0, 1'b0, instr[11:7], 1'b1, 1'b0);
    v.chk_issue = 1'b0;
    case (instr[6:0])
      7'b0110011:
        case ({f7, f3})
          {7'h00, 3'd0}: v.result = a + b;
          {7'h00, 3'd1}: v.result = a << b[4:0];
          {7'h00, 3'd2}: v.result = ($signed(a) < $signed(b)) ? 1 : 0;
          {7'h00, 3'd3}: v.result = (a < b) ? 1 : 0;
          {7'h00, 3'd4}: v.result = a ^ b;
          {7'h00, 3'd5}: v.result = a >> b[4:0];
          {7'h00, 3'd6}: v.result = a | b;
          {7'h00, 3'd7}: v.result = a & b;
          {7'h20, 3'd0}: v.result = a - b;
          {7'h20, 3'd5}: v.result = 32'($signed(a) >>> b[4:0]);
          default:       v.legal = 1'b0;
        endcase
      7'b0010011:
        case (f3)
          3'd0: v.result = a + imm;
          3'd1: if (f7 == 7'h00) v.result = a << sh; else v.legal = 1'b0;
          3'd2: v.result = ($signed(a) < $signed(imm)) ? 1 : 0;
          3'd3: v.result = (a < imm) ? 1 : 0;
          3'd4: v.result = a ^ imm;
          3'd5: if (f7 == 7'h00) v.result = a >> sh;
                else if (f7 == 7'h20) v.result = 32'($signed(a) >>> sh);
                else v.legal = 1'b0;
          3'd6: v.result = a | imm;
          default: v.result = a & imm;
        endcase
      7'b0110111: v.result = {instr[31:12], 12'b0};
      7'b0010111: v.result = pc + {instr[31:12], 12'b0};
`ifdef ALU_ISSUE_BRANCH_EN
      7'b1100011: begin
        br = 1'b1;
        v.chk_rd = 1'b0;
        case (f3)
          3'd0: begin v.result = a - b; v.taken = (a == b); end
          3'd1: begin v.result = a - b; v.taken = (a != b); end
          3'd4: begin v.result = ($signed(a) < $signed(b)) ? 1 : 0; v.taken = ($signed(a) < $signed(b)); end
          3'd5: begin v.result = ($signed(a) < $signed(b)) ? 1 : 0; v.taken = !($signed(a) < $signed(b)); end
          3'd6: begin v.result = (a < b) ? 1 : 0; v.taken = (a < b); end
          3'd7: begin v.result = (a < b) ? 1 : 0; v.taken = !(a < b); end
          default: v.legal = 1'b0;
        endcase
      end
`endif
      default: v.legal = 1'b0;
    endcase
    if (!v.legal) begin v.result = 0; v.taken = 1'b0; v.chk_rd = 1'b0; end
    v.we = v.legal && !br && (instr[11:7] != 5'd0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge in IDLE; returns on a negedge after the DONE handshake.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    logic ctr_moved;
    logic [31:0] held;
    in_instr = v.instr; in_pc = v.pc; in_rs1_val = v.rs1; in_rs2_val = v.rs2; in_valid = 1'b1;
    chk({tag, " in_ready_idle"}, {31'b0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ctr_moved = 1'b0;
    if (v.chk_issue) begin
      chk({tag, " issue_ctr"}, {28'b0, ALU_ctr}, {28'b0, v.ctr});
      chk({tag, " issue_a"}, ALU_srcA, v.a);
      chk({tag, " issue_b"}, ALU_srcB, v.b);
    end
    while (!out_valid && lat < 8) begin
      if (ALU_ctr != 4'd0) ctr_moved = 1'b1;
      if (lat == 2) chk({tag, " wait_srcA_zero"}, ALU_srcA | ALU_srcB, 0);
      chk({tag, " busy_in_ready"}, {31'b0, in_ready}, 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, v.legal ? 3 : 1);
    if (!v.legal) chk({tag, " ctr_stayed_idle"}, {31'b0, ctr_moved}, 0);
    chk({tag, " illegal"}, {31'b0, out_illegal}, {31'b0, !v.legal});
    chk({tag, " result"}, out_result, v.result);
    chk({tag, " we"}, {31'b0, out_we}, {31'b0, v.we});
    if (v.chk_rd) chk({tag, " rd"}, {27'b0, out_rd}, {27'b0, v.rd});
`ifdef ALU_ISSUE_BRANCH_EN
    chk({tag, " taken"}, {31'b0, out_taken}, {31'b0, v.taken});
`endif
    held = out_result;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_instr = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd4);
      @(negedge clk);
      chk({tag, " hold_valid"}, {31'b0, out_valid}, 1);
      chk({tag, " hold_in_ready"}, {31'b0, in_ready}, 0);
      chk({tag, " hold_result"}, out_result, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post_valid"}, {31'b0, out_valid}, 0);
    chk({tag, " post_in_ready"}, {31'b0, in_ready}, 1);
  endtask

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 0, 10, 3, 1, 4'd1, 10, 3, 7, 1, 3, 1, 0));
    vecs.push_back(mk(enc_i(12'h404, 5'd6, 3'd5, 5'd5), 0, 32'h8000_0000, 0, 1, 4'd14, 32'h8000_0000, 4,
                      32'hF800_0000, 1, 5, 1, 0));
    vecs.push_back(mk(enc_u(20'h12345, 5'd1, 7'b0010111), 32'h100, 0, 0, 1, 4'd0, 32'h100, 32'h1234_5000,
                      32'h1234_5100, 1, 1, 1, 0));
    vecs.push_back(mk(32'h0000_0000, 0, 5, 6, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(12'hFFF, 5'd2, 3'd0, 5'd7), 0, 5, 0, 1, 4'd0, 5, 32'hFFFF_FFFF, 4, 1, 7, 1, 0));
    vecs.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4), 0, 1, 32'hFFFF_FFFF, 1, 4'd15, 1, 32'hFFFF_FFFF,
                      1, 1, 4, 1, 0));
    vecs.push_back(mk(enc_u(20'hABCDE, 5'd9, 7'b0110111), 32'h40, 7, 8, 1, 4'd0, 0, 32'hABCD_E000,
                      32'hABCD_E000, 1, 9, 1, 0));
    vecs.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 0, 1, 2, 1, 4'd0, 1, 2, 3, 0, 0, 1, 0));
    vecs.push_back(mk(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 0, 4, 5, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(12'h023, 5'd1, 3'd1, 5'd3), 0, 4, 5, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd3), 0, 4, 5, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd2), 0, 32'hFFFF_FFFF, 1, 1, 4'd7, 32'hFFFF_FFFF, 1,
                      1, 1, 2, 1, 0));
`ifdef ALU_ISSUE_BRANCH_EN
    vecs.push_back(mk(enc_b(3'd6, 5'd1, 5'd2), 0, 1, 32'hFFFF_FFFF, 1, 4'd15, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1));
    vecs.push_back(mk(enc_b(3'd0, 5'd1, 5'd2), 0, 9, 9, 1, 4'd1, 9, 9, 0, 0, 0, 0, 1));
    vecs.push_back(mk(enc_b(3'd2, 5'd1, 5'd2), 0, 9, 9, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk(enc_b(3'd6, 5'd1, 5'd2), 0, 1, 32'hFFFF_FFFF, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
`endif

    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    chk("reset_ctr", {28'b0, ALU_ctr}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 1);
    chk("post_reset_out_valid", {31'b0, out_valid}, 0);
    chk("post_reset_ctr", {28'b0, ALU_ctr}, 0);
    chk("post_reset_src", ALU_srcA | ALU_srcB, 0);
    chk("post_reset_outs", {out_result[31:7], out_rd, out_we, out_illegal}, 0);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], (i == 0) ? 5 : 0, $sformatf("vec%0d", i));

    for (int n = 0; n < 80; n++) begin
      logic [31:0] w, pc, a, b;
      int cls = $urandom_range(0, 5);
      logic [6:0] f7s;
      w = $urandom; pc = $urandom; a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
      case ($urandom_range(0, 7))
        0, 1, 2: f7s = 7'h00;
        3, 4:    f7s = 7'h20;
        default: f7s = 7'($urandom);
      endcase
      case (cls)
        0: w = enc_r(f7s, w[24:20], w[19:15], w[14:12], w[11:7]);
        1: w = enc_i({f7s, w[24:20]}, w[19:15], w[14:12], w[11:7]);
        2: w = enc_u(w[31:12], w[11:7], 7'b0110111);
        3: w = enc_u(w[31:12], w[11:7], 7'b0010111);
        4: w = enc_b(w[14:12], w[19:15], w[24:20]);
        default: ;
      endcase
      run_vec(ref_model(w, pc, a, b), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); in_rs1_val = 1; in_rs2_val = 2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_seq_issue_ctr", {28'b0, ALU_ctr}, 0);
    chk("rst_seq_issue_busy", {31'b0, in_ready}, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_seq_in_ready", {31'b0, in_ready}, 1);
    chk("rst_seq_out_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_no_valid%0d", k), {31'b0, out_valid}, 0);
    end
    chk("rst_seq_ctr_idle", {28'b0, ALU_ctr}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller driving the registered integer ALU.
- Accepts one RV32I integer instruction at a time with its PC and source-register values over a valid/ready handshake.
- Decodes it into the ALU's 4-bit operation code and its two 32-bit operands, then waits out the ALU's one-cycle registered latency.
- Captures the ALU result and returns it with destination and write-enable over a second valid/ready handshake.
- Sits between the decode/register-read stage and writeback.

## Interface
Parameters:
- IDLE_CTR, 4'b0000: value driven on ALU_ctr in every state except ISSUE.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept; high only in IDLE
- in_instr  in  32  RV32I instruction word
- in_pc  in  32  instruction PC
- in_rs1_val  in  32  rs1 value
- in_rs2_val  in  32  rs2 value
- ALU_ctr  out  4  ALU operation code
- ALU_srcA  out  32  ALU operand A
- ALU_srcB  out  32  ALU operand B
- ALU_resp  in  32  registered ALU result
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- out_result  out  32  captured ALU result
- out_rd  out  5  destination register
- out_we  out  1  write rd (0 when rd=0, for branches, and for illegal instructions)
- out_illegal  out  1  instruction not decodable
- out_taken  out  1  branch taken; present only with ALU_ISSUE_BRANCH_EN

## Operation
ALU operation codes:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7, SRA=14, SLTU=15.

States: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch instr, pc, rs1 and rs2 values, and the decode result.
  - Legal instruction -> ISSUE.
  - Illegal instruction -> DONE with out_illegal=1, out_result=0, out_we=0.
- ISSUE (one cycle): drive ALU_ctr, ALU_srcA and ALU_srcB from the latched decode; the ALU registers them at the edge that ends ISSUE. -> WAIT.
- WAIT (one cycle): sample ALU_resp into out_result at the edge that ends WAIT. Compute out_taken at the same edge. -> DONE.
- DONE: out_valid=1. out_* held stable until out_ready=1; then -> IDLE.

Decode rules:
- Opcode 0110011 (R-type): operand A = rs1, operand B = rs2.
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA.
  - Any other funct7/funct3 combination is illegal.
- Opcode 0010011 (I-type): operand A = rs1, operand B = sign-extended imm[31:20].
  - funct3 mapping as for R-type, but funct3 000 is always ADD.
  - 001 requires imm[11:5]=0.
  - 101 requires imm[11:5] of 0000000 (SRL) or 0100000 (SRA).
  - Any other imm[11:5] value on 001 or 101 is illegal.
- Opcode 0110111 (LUI): ADD, operand A = 0, operand B = {instr[31:12], 12'b0}.
- Opcode 0010111 (AUIPC): ADD, operand A = pc, operand B = {instr[31:12], 12'b0}.
- Branches: see Configuration.
- All other opcodes are illegal.

Reset state and outputs:
- State = IDLE, so in_ready=1 after reset.
- out_valid, out_result, out_rd, out_we, out_illegal, out_taken = 0.
- ALU_ctr = IDLE_CTR; ALU_srcA = ALU_srcB = 0.

## Timing
- Accept edge E0 (in_valid & in_ready) -> ISSUE in the cycle after E0 -> WAIT after E1 -> out_valid=1 after E2.
- Legal instruction: result three cycles after acceptance.
- Illegal instruction: out_valid=1 in the cycle after E0.
- Only one instruction in flight; in_valid is ignored outside IDLE.
- A new instruction is accepted no earlier than the cycle after the DONE handshake; no same-cycle bypass.
- ALU_srcA and ALU_srcB are 0 outside ISSUE.
- A reset assertion in any state returns to IDLE asynchronously; the in-flight instruction is dropped and no out_valid is produced for it.

## Configuration
ALU_ISSUE_BRANCH_EN
- Defined: opcode 1100011 decodes with operand A = rs1, operand B = rs2, out_we=0.
  - BEQ and BNE use SUB; taken when result==0 and result!=0 respectively.
  - BLT and BGE use SLT; taken when result[0]==1 and result[0]==0 respectively.
  - BLTU and BGEU use SLTU with the same rule as BLT/BGE.
  - funct3 010 and 011 are illegal.
- Undefined: opcode 1100011 is illegal and the out_taken port does not exist.

## Test plan
- Reset: after resetn release -> in_ready=1, out_valid=0, ALU_ctr=IDLE_CTR.
- SUB x3,x1,x2 with rs1=10, rs2=3; ALU model returns 7 -> ISSUE drives ctr=1, A=10, B=3; out_valid three cycles after accept with result 7, rd=3, we=1.
- SRAI x5,x6,4 (imm[11:5]=0100000) and AUIPC x1,0x12345 at pc=0x100 -> ctr=14 with B=4; then ctr=0 with A=0x100, B=0x12345000.
- Opcode 0000000 -> out_valid in the cycle after accept, illegal=1, we=0; ALU_ctr never leaves IDLE_CTR.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses in that window are ignored.
- With ALU_ISSUE_BRANCH_EN: BLTU rs1=1, rs2=0xFFFFFFFF -> ctr=15, taken=1, we=0. Separately, resetn asserted during WAIT -> IDLE immediately, no out_valid.
